// File: rtl/voq_sched_pkg.sv
// Shared switch definitions: port index sizing, scheduler states and
// default port count.
package switch_defs;

    localparam int DEF_N_PORTS = 4;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [idx_w(DEF_N_PORTS)-1:0] port_idx_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ACCEPT,
        S_DONE
    } sched_state_t;

endpackage

// File: rtl/voq_sched_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, modulo N.
// Rotate, priority-encode, rotate back; purely combinational.
module rr_arbiter
    import switch_defs::*;
#(
    parameter int N = DEF_N_PORTS,
    parameter int W = idx_w(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt
);

    logic [N-1:0] rot;
    logic [N-1:0] pick;
    logic         found;

    always_comb begin
        rot   = '0;
        pick  = '0;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            rot[k] = req[(k + int'(ptr)) % N];
        end
        for (int k = 0; k < N; k++) begin
            if (rot[k] && !found) begin
                pick[k] = 1'b1;
                found   = 1'b1;
            end
        end
        for (int m = 0; m < N; m++) begin
            gnt[m] = pick[(m + N - int'(ptr)) % N];
        end
    end

endmodule

// File: rtl/voq_sched.sv
// iSLIP crossbar scheduler: one conflict-free ingress/egress match
// per cell slot, published with a one-cycle grant_valid pulse.
module voq_sched
    import switch_defs::*;
#(
    parameter int N_PORTS     = DEF_N_PORTS,
    parameter int ITERS       = 2,
    parameter int SLOT_CYCLES = 8
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  experimenting,
    input  logic [N_PORTS*N_PORTS-1:0]            voq_req,
    output logic                                  sched_busy,
    output logic                                  grant_valid,
    output logic [N_PORTS-1:0]                    in_match,
    output logic [N_PORTS-1:0]                    out_match,
    output logic [N_PORTS*idx_w(N_PORTS)-1:0]     out_sel,
    output logic [31:0]                           match_cnt
);

    localparam int N  = N_PORTS;
    localparam int W  = idx_w(N_PORTS);
    localparam int CW = idx_w(SLOT_CYCLES);
    localparam int IW = idx_w(ITERS);

    sched_state_t state, state_d;

    logic [CW-1:0]         slot_cnt;
    logic                  exp_q;
    logic                  tick;
    logic                  rise;
    logic                  last_iter;
    logic [IW-1:0]         iter;
    logic [N*N-1:0]        snap;
    logic [N-1:0]          in_m, out_m, in_n, out_n;
    logic [N*W-1:0]        sel_w, sel_n;
    logic [N-1:0][W-1:0]   g_ptr, a_ptr, pg, pa, pg_n, pa_n;
    logic [N-1:0][N-1:0]   greq, gnt_c, gq, areq, acc;

    assign tick        = experimenting && (slot_cnt == CW'(SLOT_CYCLES - 1));
    assign rise        = experimenting && !exp_q;
    assign last_iter   = (iter == IW'(ITERS - 1));
    assign sched_busy  = (state != S_IDLE);
    assign grant_valid = (state == S_DONE);

    // greq[j] is egress j's view; areq[i] is ingress i's view of grants.
    always_comb begin
        greq = '0;
        areq = '0;
        for (int j = 0; j < N; j++) begin
            for (int i = 0; i < N; i++) begin
                greq[j][i] = snap[i*N+j] & ~in_m[i] & ~out_m[j];
                areq[i][j] = gq[j][i] & ~in_m[i];
            end
        end
    end

    for (genvar p = 0; p < N; p++) begin : g_arb
        rr_arbiter #(.N(N), .W(W)) u_gnt (
            .req (greq[p]),
            .ptr (g_ptr[p]),
            .gnt (gnt_c[p])
        );
        rr_arbiter #(.N(N), .W(W)) u_acc (
            .req (areq[p]),
            .ptr (a_ptr[p]),
            .gnt (acc[p])
        );
    end

    always_comb begin
        in_n  = in_m;
        out_n = out_m;
        sel_n = sel_w;
        pg_n  = pg;
        pa_n  = pa;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (acc[i][j]) begin
                    in_n[i]          = 1'b1;
                    out_n[j]         = 1'b1;
                    sel_n[i*W +: W]  = W'(j);
                    if (iter == '0) begin
                        pg_n[j] = W'(i + 1);
                        pa_n[i] = W'(j + 1);
                    end
                end
            end
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            S_IDLE:   if (tick) state_d = S_GRANT;
            S_GRANT:  state_d = experimenting ? S_ACCEPT : S_IDLE;
            S_ACCEPT: begin
                if (!experimenting) state_d = S_IDLE;
                else if (last_iter) state_d = S_DONE;
                else                state_d = S_GRANT;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            slot_cnt  <= '0;
            exp_q     <= 1'b0;
            iter      <= '0;
            snap      <= '0;
            in_m      <= '0;
            out_m     <= '0;
            sel_w     <= '0;
            gq        <= '0;
            g_ptr     <= '0;
            a_ptr     <= '0;
            pg        <= '0;
            pa        <= '0;
            in_match  <= '0;
            out_match <= '0;
            out_sel   <= '0;
            match_cnt <= '0;
        end else begin
            state <= state_d;
            exp_q <= experimenting;
            if (!experimenting || tick) slot_cnt <= '0;
            else                        slot_cnt <= slot_cnt + CW'(1);
            if (rise) match_cnt <= '0;
            unique case (state)
                S_IDLE: begin
                    if (tick) begin
                        snap  <= voq_req;
                        in_m  <= '0;
                        out_m <= '0;
                        sel_w <= '0;
                        iter  <= '0;
                        pg    <= g_ptr;
                        pa    <= a_ptr;
                    end
                end
                S_GRANT: gq <= gnt_c;
                S_ACCEPT: begin
                    in_m  <= in_n;
                    out_m <= out_n;
                    sel_w <= sel_n;
                    pg    <= pg_n;
                    pa    <= pa_n;
                    iter  <= iter + IW'(1);
                    // Publish on the edge into DONE so outputs are valid with the pulse.
                    if (experimenting && last_iter) begin
                        g_ptr     <= pg_n;
                        a_ptr     <= pa_n;
                        in_match  <= in_n;
                        out_match <= out_n;
                        out_sel   <= sel_n;
                        match_cnt <= match_cnt + 32'($countones(in_n));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/voq_sched.md
Name: voq_sched

Overview:
- Crossbar scheduler for the switch datapath. Runs single-cell-slot iSLIP round-robin matching between N ingress packet generators and N egress validators.
- Each slot it snapshots the virtual-output-queue occupancy matrix and computes a conflict-free ingress→egress match. It then publishes the match to the crossbar and ingress dequeue logic.
- Gated by the sw-driven `experimenting` flag from the hw/sw interface.

Parameters:
- N_PORTS, 4, number of ingress and egress ports (power of 2, ≥2).
- ITERS, 2, iSLIP iterations per slot (1..N_PORTS).
- SLOT_CYCLES, 8, clock cycles per cell slot; must be ≥ 2*ITERS+2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- experimenting  in  1  scheduling enabled while high.
- voq_req  in  N*N  bit i*N+j = ingress i holds a cell for egress j.
- sched_busy  out  1  high from snapshot through DONE.
- grant_valid  out  1  one-cycle pulse: new match published.
- in_match  out  N  bit i = ingress i matched this slot.
- out_match  out  N  bit j = egress j matched this slot.
- out_sel  out  N*$clog2(N)  field i = egress index assigned to ingress i; 0 if unmatched.
- match_cnt  out  32  cumulative matched pairs since reset or since the last rising edge of `experimenting`.

Behaviour:
- One clock domain. Reset is asynchronous and active-high, using the port names clk and reset. On reset all outputs are 0, all pointers are 0, the slot counter is 0 and the FSM is IDLE.
- Slot counter:
  - Counts 0..SLOT_CYCLES-1 while `experimenting` is high. It wraps to 0.
  - It holds at 0 while `experimenting` is low.
  - `tick` is true when the count is SLOT_CYCLES-1.
- FSM states and transitions:
  - IDLE: on `tick`, snapshot `voq_req`, clear the working masks, set iter=0, go to GRANT.
  - GRANT (1 cycle): each unmatched egress j with requests from unmatched ingresses grants the first such ingress at or after g[j], scanning modulo N.
  - ACCEPT (1 cycle): each unmatched ingress i that received grants accepts the first granting egress at or after a[i], modulo N. Set the match bits and out_sel. If iter==0, record the pending pointer updates g[j]←(i+1)%N and a[i]←(j+1)%N. If iter<ITERS-1, increment iter and go to GRANT; otherwise go to DONE.
  - DONE (1 cycle): commit pending pointers, drive in_match/out_match/out_sel, pulse grant_valid, add popcount(in_match) to match_cnt, go to IDLE.
- Only first-iteration accepts update pointers (iSLIP rule). Later iterations only fill unmatched ports.
- Latency: `tick` at cycle t gives grant_valid at t+2*ITERS+1. Match outputs hold until the next DONE.
- An empty request matrix still produces a grant_valid pulse, with all masks 0 and match_cnt unchanged.
- `experimenting` falling while the FSM is in GRANT or ACCEPT aborts the slot:
  - next cycle the FSM is IDLE and grant_valid does not pulse;
  - pointers and outputs keep their previous values, because pending updates are discarded.
- `experimenting` rising edge clears match_cnt, leaves the pointers unchanged and restarts the slot count at 0.
- `voq_req` changes after the snapshot are ignored until the next tick.
- Invariant: each ingress and each egress appears in at most one matched pair. popcount(in_match) == popcount(out_match).

Decomposition:
- The shared package (switch_defs) holds:
  - the port-index width function and port_idx_t;
  - the scheduler FSM state enum;
  - the default N_PORTS.
- One sub-module, rr_arbiter: an N-bit request vector plus a pointer produces a one-hot grant (rotate, priority-encode, rotate back). It is purely combinational and instantiated 2*N times (grant arbiters and accept arbiters).

Test Plan (N=4, ITERS=2, SLOT_CYCLES=8):
1. Timing: `experimenting` rises at cycle 0 with voq_req = bit 2*4+3 only → tick at cycle 7; grant_valid at cycle 12; in_match=0100, out_match=1000, out_sel[2]=3; g[3]=3, a[2]=0; match_cnt=1.
2. Full matrix (all 16 bits), pointers reset:
   - Slot 1 gives matches (0,0),(1,1); then g[0]=1, a[0]=1.
   - Slot 2 gives matches (0,1),(1,0),(2,2); match_cnt=5.
3. voq_req=0 → grant_valid pulses with in_match=out_match=0, out_sel all 0; match_cnt unchanged; pointers unchanged.
4. Drop `experimenting` during the first GRANT cycle of a full-matrix slot → no grant_valid; FSM IDLE next cycle. Re-enabling and running a slot reproduces scenario 2 slot 1, because pointers were not updated.
5. Assert reset asynchronously mid-ACCEPT → all outputs 0 before the next clk edge. After release, the first slot behaves as from power-up.
6. Randomised 1000 slots → checker confirms no ingress/egress is matched twice, every match corresponds to a snapshot request, and match_cnt equals the scoreboard sum.
